// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit: one shift-add or restoring-divide step per cycle,
// with sign handling wrapped around an unsigned magnitude core.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] accHi_q, accHi_d;
    logic [31:0] accLo_q, accLo_d;
    logic [31:0] operandB_q, operandB_d;
    logic [31:0] rawA_q, rawA_d;
    logic        negA_q, negA_d;
    logic        negB_q, negB_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        divByZero_q, divByZero_d;

    logic [31:0] magA, magB;
    logic [32:0] multSum;
    logic [32:0] divShift;
    logic        divGe;
    logic [31:0] divRem;
    logic [31:0] stepHi, stepLo;
    logic [63:0] product, productNeg;

    // Signed ops work on magnitudes; 32'h80000000 keeps its bit pattern as an unsigned magnitude.
    assign magA = (!op[0] && A[31]) ? (32'd0 - A) : A;
    assign magB = (!op[0] && B[31]) ? (32'd0 - B) : B;

    assign multSum  = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operandB_q} : 33'd0);
    assign divShift = {accHi_q, accLo_q[31]};
    assign divGe    = (divShift >= {1'b0, operandB_q});
    assign divRem   = divShift[31:0] - operandB_q;

    always_comb begin
        if (op_q[1]) begin
            stepHi = divGe ? divRem : divShift[31:0];
            stepLo = {accLo_q[30:0], divGe};
        end else begin
            stepHi = multSum[32:1];
            stepLo = {multSum[0], accLo_q[31:1]};
        end
    end

    assign product    = {stepHi, stepLo};
    assign productNeg = 64'd0 - product;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        accHi_d     = accHi_q;
        accLo_d     = accLo_q;
        operandB_d  = operandB_q;
        rawA_d      = rawA_q;
        negA_d      = negA_q;
        negB_d      = negB_q;
        op_d        = op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        divByZero_d = divByZero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    count_d     = 5'd0;
                    accHi_d     = 32'd0;
                    accLo_d     = magA;
                    operandB_d  = magB;
                    rawA_d      = A;
                    negA_d      = !op[0] && A[31];
                    negB_d      = !op[0] && B[31];
                    op_d        = op;
                    divByZero_d = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                accHi_d = stepHi;
                accLo_d = stepLo;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = DONE;
                    // Final step results are used directly so HI/LO land on the RUN->DONE edge.
                    if (op_q[1]) begin
                        if (operandB_q == 32'd0) begin
                            hi_d        = rawA_q;
                            lo_d        = 32'hFFFF_FFFF;
                            divByZero_d = 1'b1;
                        end else begin
                            lo_d = (negA_q ^ negB_q) ? (32'd0 - stepLo) : stepLo;
                            hi_d = negA_q ? (32'd0 - stepHi) : stepHi;
                        end
                    end else begin
                        {hi_d, lo_d} = (negA_q ^ negB_q) ? productNeg : product;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            accHi_q     <= 32'd0;
            accLo_q     <= 32'd0;
            operandB_q  <= 32'd0;
            rawA_q      <= 32'd0;
            negA_q      <= 1'b0;
            negB_q      <= 1'b0;
            op_q        <= 2'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            accHi_q     <= accHi_d;
            accLo_q     <= accLo_d;
            operandB_q  <= operandB_d;
            rawA_q      <= rawA_d;
            negA_q      <= negA_d;
            negB_q      <= negB_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            divByZero_q <= divByZero_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign div_by_zero = divByZero_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only when not busy.
REQ-005 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 A  input  32  operand rs / dividend, driven from register bank Dato1.
REQ-007 B  input  32  operand rt / divisor, driven from register bank Dato2.
REQ-008 busy  output  1  operation in progress; new start ignored.
REQ-009 done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-010 HI  output  32  upper product / remainder register.
REQ-011 LO  output  32  lower product / quotient register.
REQ-012 div_by_zero  output  1  set with done when a DIV/DIVU had B=0; cleared at next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; reset state is IDLE.
REQ-014 IDLE/DONE: start=1 at an edge SHALL latch A, B, op, clear a 5-bit iteration counter, and move to RUN; start=0 in DONE returns to IDLE.
REQ-015 RUN SHALL last exactly 32 cycles (counter 0..31, one shift-add or shift-subtract step per cycle), then move to DONE.
REQ-016 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-017 Latency: start sampled at edge E0 -> busy high after E0..E32 -> done high for the cycle after E32; back-to-back start in the DONE cycle SHALL be accepted with no bubble.
REQ-018 start, A, B, op changes while busy SHALL be ignored; operands are used only as latched at E0.
REQ-019 HI/LO SHALL update only on the RUN->DONE edge and hold their values otherwise, including across IDLE.
REQ-020 MULT/MULTU: {HI,LO} = full 64-bit product; signed mode uses magnitudes internally and negates the 64-bit result when operand signs differ.
REQ-021 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-022 Divide by zero (B=0): same 33-cycle latency, LO=32'hFFFFFFFF, HI=A, div_by_zero=1.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0, div_by_zero=0.
REQ-024 Operand 0 in multiply or dividend 0 SHALL give HI=LO=0 at normal latency.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, div_by_zero=0, HI=0, LO=0, counter=0, regardless of state.
REQ-026 rst during RUN SHALL abort the operation; no done pulse and no HI/LO update for the aborted operation.
REQ-027 rst and start asserted at the same edge: rst wins; start ignored.

Verification
REQ-028 MULTU A=10, B=15 -> done 33 cycles after start, HI=0, LO=32'h00000096.
REQ-029 MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001; MULT A=-3, B=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
REQ-030 DIV A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU A=100, B=7 -> LO=14, HI=2.
REQ-031 DIVU A=100, B=0 -> LO=32'hFFFFFFFF, HI=32'h00000064, div_by_zero=1 with done; next start clears div_by_zero.
REQ-032 Start MULTU 10*15, pulse start with A=B=0 at RUN cycle 5 -> ignored, LO=150; start held high through the DONE cycle -> second operation accepted, done again exactly 33 cycles later.
REQ-033 Start DIVU, assert rst at RUN cycle 10 -> next cycle busy=0, HI=LO=0, no done pulse within 40 cycles.
